// File: rtl/decode_regfile_sb.sv
// decode_regfile_sb: decode-stage GPR bank with HI/LO pair and a per-register
// pending-write scoreboard that raises a zero-latency decode stall.
// Register 0 is hard-wired to zero. The link (ra) write wins over a
// same-cycle writeback to RA_ID.
// Optional macro DECODE_RF_BYPASS_EN: write-through read bypass, and a
// register whose final outstanding write lands this cycle no longer stalls.
// Handshake: an issue is accepted only when issue_valid && issue_ready.
// issue_valid with issue_ready low is ignored by the scoreboard and stalls decode.
module decode_regfile_sb #(
   parameter int DATA_WIDTH  = 32,
   parameter int REG_COUNT   = 32,
   parameter int NUM_READ    = 2,
   parameter int MAX_PENDING = 3,
   parameter int RA_ID       = 31,
   localparam int ID_W       = $clog2(REG_COUNT),
   localparam int CNT_W      = $clog2(MAX_PENDING + 1)
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic [NUM_READ*ID_W-1:0]       rd_id,
   output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
   input  logic                           wb_en,
   input  logic [ID_W-1:0]                wb_id,
   input  logic [DATA_WIDTH-1:0]          wb_data,
   input  logic                           ra_write,
   input  logic [DATA_WIDTH-1:0]          ra_data,
   input  logic                           hilo_wb_en,
   input  logic [DATA_WIDTH-1:0]          hi_wb,
   input  logic [DATA_WIDTH-1:0]          lo_wb,
   input  logic                           issue_valid,
   input  logic                           issue_reg_write,
   input  logic [ID_W-1:0]                issue_dest,
   input  logic                           issue_hilo,
   input  logic [NUM_READ-1:0]            rd_used,
   input  logic                           hilo_used,
   output logic [DATA_WIDTH-1:0]          hi_value,
   output logic [DATA_WIDTH-1:0]          lo_value,
   output logic [DATA_WIDTH-1:0]          syscall_funct,
   output logic [DATA_WIDTH-1:0]          syscall_param_1,
   output logic                           stall,
   output logic                           issue_ready
);

   // Read slots: the NUM_READ operand ports followed by the two syscall taps.
   localparam int NP = NUM_READ + 2;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

   logic [DATA_WIDTH-1:0] gpr_q [REG_COUNT];
   logic [DATA_WIDTH-1:0] gpr_d [REG_COUNT];
   logic [CNT_W-1:0]      cnt_q [REG_COUNT];
   logic [CNT_W-1:0]      cnt_d [REG_COUNT];
   logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [CNT_W-1:0]      hilo_cnt_q, hilo_cnt_d;

   logic [ID_W-1:0]       rid      [NP];
   logic [DATA_WIDTH-1:0] rval     [NP];
   logic                  rbusy    [NP];
   logic                  accept;
   logic                  hilo_busy;

   // Scoreboard admission: a full destination counter blocks the issue.
   always_comb begin
      issue_ready = 1'b1;
      if (issue_reg_write && (cnt_q[issue_dest] == CNT_MAX)) issue_ready = 1'b0;
      if (issue_hilo && (hilo_cnt_q == CNT_MAX))             issue_ready = 1'b0;
      accept = issue_valid && issue_ready;
   end

   // Next-state for the register array, HI/LO and all pending counters.
   always_comb begin
      gpr_d = gpr_q;
      cnt_d = cnt_q;
      hi_d  = hi_q;
      lo_d  = lo_q;
      for (int r = 1; r < REG_COUNT; r++) begin
         logic inc, dec;
         if (ra_write && (r == RA_ID))                    gpr_d[r] = ra_data;
         else if (wb_en && (wb_id == ID_W'(r)))           gpr_d[r] = wb_data;
         inc = accept && issue_reg_write && (issue_dest == ID_W'(r));
         dec = wb_en && (wb_id == ID_W'(r)) && (cnt_q[r] != '0);
         if (inc && !dec)      cnt_d[r] = cnt_q[r] + 1'b1;
         else if (dec && !inc) cnt_d[r] = cnt_q[r] - 1'b1;
      end
      if (hilo_wb_en) begin
         hi_d = hi_wb;
         lo_d = lo_wb;
      end
      hilo_cnt_d = hilo_cnt_q;
      if ((accept && issue_hilo) && !(hilo_wb_en && (hilo_cnt_q != '0)))
         hilo_cnt_d = hilo_cnt_q + 1'b1;
      else if (!(accept && issue_hilo) && (hilo_wb_en && (hilo_cnt_q != '0)))
         hilo_cnt_d = hilo_cnt_q - 1'b1;
   end

   // State registers; reset drops every value and every pending write.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < REG_COUNT; r++) begin
            gpr_q[r] <= '0;
            cnt_q[r] <= '0;
         end
         hi_q       <= '0;
         lo_q       <= '0;
         hilo_cnt_q <= '0;
      end else begin
         gpr_q      <= gpr_d;
         cnt_q      <= cnt_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         hilo_cnt_q <= hilo_cnt_d;
      end
   end

   // Read slots: array value (optionally bypassed) and per-slot busy flag.
   always_comb begin
      for (int k = 0; k < NUM_READ; k++) rid[k] = rd_id[k*ID_W +: ID_W];
      rid[NUM_READ]     = ID_W'(2);
      rid[NUM_READ + 1] = ID_W'(4);
      for (int k = 0; k < NP; k++) begin
         rval[k]  = gpr_q[rid[k]];
         rbusy[k] = (cnt_q[rid[k]] != '0);
`ifdef DECODE_RF_BYPASS_EN
         if (wb_en && (wb_id == rid[k])) begin
            rval[k] = wb_data;
            if (cnt_q[rid[k]] == CNT_W'(1)) rbusy[k] = 1'b0;
         end
         if (ra_write && (rid[k] == ID_W'(RA_ID))) rval[k] = ra_data;
`endif
         if (rid[k] == '0) rval[k] = '0;
      end
   end

   // Output mapping and HI/LO read path.
   always_comb begin
      for (int k = 0; k < NUM_READ; k++) rd_data[k*DATA_WIDTH +: DATA_WIDTH] = rval[k];
      syscall_funct   = rval[NUM_READ];
      syscall_param_1 = rval[NUM_READ + 1];
      hi_value  = hi_q;
      lo_value  = lo_q;
      hilo_busy = (hilo_cnt_q != '0);
`ifdef DECODE_RF_BYPASS_EN
      if (hilo_wb_en) begin
         hi_value = hi_wb;
         lo_value = lo_wb;
         if (hilo_cnt_q == CNT_W'(1)) hilo_busy = 1'b0;
      end
`endif
   end

   // Decode stall: needed operand still pending, or a rejected issue.
   always_comb begin
      stall = issue_valid && !issue_ready;
      for (int k = 0; k < NUM_READ; k++)
         if (rd_used[k] && rbusy[k]) stall = 1'b1;
      if (hilo_used && hilo_busy) stall = 1'b1;
   end

endmodule

// File: doc/decode_regfile_sb.md
Name: decode_regfile_sb

Overview:
- Parametrised successor to the decode-stage register file.
- Multi-port GPR bank plus HI/LO pair, with a per-register pending-write scoreboard that raises a decode stall.
- Sits in the decode stage; read ports feed operand values.
- Writeback stage drives the GPR write port and the HI/LO write port; decode drives issue notifications and the link (ra) write.

Parameters:
- DATA_WIDTH, 32, width of every register.
- REG_COUNT, 32, number of GPRs (power of 2); ID_W = $clog2(REG_COUNT).
- NUM_READ, 2, number of read ports.
- MAX_PENDING, 3, maximum in-flight writes tracked per register; CNT_W = $clog2(MAX_PENDING+1).
- RA_ID, 31, register written by the link port.

Ports:
- clock, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- rd_id, input, NUM_READ*ID_W, packed read register ids; port k is at bits [k*ID_W +: ID_W].
- rd_data, output, NUM_READ*DATA_WIDTH, packed read values.
- wb_en, input, 1, GPR writeback enable.
- wb_id, input, ID_W, writeback register id.
- wb_data, input, DATA_WIDTH, writeback value.
- ra_write, input, 1, link write from decode.
- ra_data, input, DATA_WIDTH, link value.
- hilo_wb_en, input, 1, HI/LO writeback enable.
- hi_wb, input, DATA_WIDTH, HI writeback value.
- lo_wb, input, DATA_WIDTH, LO writeback value.
- issue_valid, input, 1, an instruction leaves decode this cycle.
- issue_reg_write, input, 1, the issued instruction writes a GPR.
- issue_dest, input, ID_W, destination of the issued instruction.
- issue_hilo, input, 1, the issued instruction writes HI/LO.
- rd_used, input, NUM_READ, per-port flag: the operand is actually needed.
- hilo_used, input, 1, the decoding instruction reads HI/LO (MFHI/MFLO).
- hi_value, output, DATA_WIDTH, current HI.
- lo_value, output, DATA_WIDTH, current LO.
- syscall_funct, output, DATA_WIDTH, live value of register 2.
- syscall_param_1, output, DATA_WIDTH, live value of register 4.
- stall, output, 1, decode must hold.
- issue_ready, output, 1, scoreboard can accept the issued destination.

Behaviour:
- Reset (async, reset_n low):
  - All GPRs, HI, LO and pending counters clear to 0.
  - stall = 0, issue_ready = 1, all data outputs = 0.
- Register 0 reads 0 always.
  - Writes to it are dropped.
  - Issues to it are never counted.
- Writes occur at the rising edge.
  - Same-cycle wb_en and ra_write, both targeting RA_ID: ra_data wins, because link is the younger instruction.
  - Same-cycle writes to different registers both commit.
- HI/LO written together on hilo_wb_en.
- Reads are combinational from the array.
  - syscall_funct and syscall_param_1 follow the same read/bypass rules as rd_data.
- Scoreboard, per register: counter cnt[r].
  - Increment on issue_valid & issue_reg_write & issue_dest!=0 & issue_ready.
  - Decrement on wb_en & wb_id!=0 & cnt>0.
  - Increment and decrement of the same register in the same cycle: cnt unchanged.
  - Decrement at cnt==0 is ignored (ra_write never touches the scoreboard).
- HI/LO scoreboard: separate counter with the same rules, driven by issue_hilo and hilo_wb_en.
- issue_ready = 0 when the issued destination's counter == MAX_PENDING, or when issue_hilo and the HI/LO counter == MAX_PENDING.
  - issue_valid while issue_ready is low has no scoreboard effect.
- stall = 1 if any of the following holds (combinational, zero latency):
  - a port k with rd_used[k] reads a register with cnt>0 that is not cleared by the bypass rule;
  - hilo_used with HI/LO cnt>0 that is not cleared by the bypass rule;
  - issue_valid & ~issue_ready.
- Reset asserted mid-operation discards all pending state immediately.

Optional Feature:
- Macro: DECODE_RF_BYPASS_EN.
- Defined:
  - Write-through bypass. A read whose id matches an enabled same-cycle write returns the incoming value; ra_data takes priority over wb_data. hi_value/lo_value are bypassed likewise.
  - A register with cnt==1 that is being written back this cycle does not stall.
- Undefined:
  - Reads return the pre-edge array value.
  - Any cnt>0 stalls, including the final writeback cycle.

Test Plan:
- Reset: assert reset_n=0 mid-run after writes -> all rd_data=0, stall=0, issue_ready=1, hi/lo=0.
- Write r5=0xDEADBEEF via wb; read r5 on ports 0 and 1 next cycle -> both 0xDEADBEEF; write r0=0x1234 -> r0 still reads 0.
- Issue dest r7, then read r7 with rd_used=1 -> stall=1; writeback r7=0x55 with bypass on -> stall=0 and rd_data=0x55 that cycle; bypass off -> stall=1 that cycle and 0 the next.
- Issue r3 three times (MAX_PENDING=3), fourth issue -> issue_ready=0, stall=1, cnt stays 3; same-cycle issue r3 + wb r3 -> cnt unchanged.
- wb_en r31=0x10 and ra_write=0x20 in the same cycle -> r31 reads 0x20.
- Issue a HI/LO write, then MFHI with hilo_used=1 -> stall until hilo_wb_en with hi=0xA, lo=0xB; then hi_value=0xA, lo_value=0xB; syscall_funct tracks an r2 write of 0xA.
